// File: rtl/uart_rx.sv
// 8N1 UART receiver: a two-flop synchronizer feeds a start/data/stop FSM.
// The FSM samples each bit near its centre using a down-counting bit-period divider.
module uart_rx #(
    parameter int DIV_RATE  = 260,
    parameter int DIV_CNT_W = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       rx_busy,
    output logic       rx_end,
    output logic       rx_frame_err,
    output logic [7:0] rx_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [DIV_CNT_W-1:0] DIV_FULL = DIV_CNT_W'(DIV_RATE);
    localparam logic [DIV_CNT_W-1:0] DIV_HALF = DIV_CNT_W'(DIV_RATE / 2);
    localparam logic [DIV_CNT_W-1:0] DIV_ONE  = DIV_CNT_W'(1);
    localparam logic [DIV_CNT_W-1:0] DIV_ZERO = DIV_CNT_W'(0);

    logic                 rx_meta;
    logic                 rx_sync;
    logic                 rx_prev;
    state_t               state;
    logic [DIV_CNT_W-1:0] div_cnt;
    logic [2:0]           bit_cnt;
    logic [7:0]           shift_reg;

    state_t               state_nxt;
    logic [DIV_CNT_W-1:0] div_nxt;
    logic [2:0]           bit_nxt;
    logic [7:0]           shift_nxt;
    logic [7:0]           data_nxt;
    logic                 end_nxt;
    logic                 err_nxt;
    logic                 sample;
    logic                 fall_edge;

    // Input synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign sample    = (div_cnt == DIV_ZERO);
    // A line held low never shows prev=1/cur=0, so it cannot start a frame.
    assign fall_edge = rx_prev & ~rx_sync;

    // Next-state, divider, bit counter, shift register and output pulse logic.
    always_comb begin
        state_nxt = state;
        div_nxt   = div_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift_reg;
        data_nxt  = rx_data;
        end_nxt   = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (fall_edge) begin
                    state_nxt = START;
                    div_nxt   = DIV_HALF;
                    bit_nxt   = 3'd0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            START, DATA, STOP: begin
                if (!sample) begin
                    div_nxt = div_cnt - DIV_ONE;
                end else begin
                    div_nxt = DIV_FULL;
                    case (state)
                        START: begin
                            if (!rx_sync) begin
                                state_nxt = DATA;
                                bit_nxt   = 3'd0;
                            end else begin
                                state_nxt = IDLE;
                            end
                        end
                        DATA: begin
                            shift_nxt = {rx_sync, shift_reg[7:1]};
                            if (bit_cnt == 3'd7) begin
                                state_nxt = STOP;
                            end else begin
                                bit_nxt = bit_cnt + 3'd1;
                            end
                        end
                        STOP: begin
                            state_nxt = IDLE;
                            if (rx_sync) begin
                                data_nxt = shift_reg;
                                end_nxt  = 1'b1;
                            end else begin
                                err_nxt  = 1'b1;
                            end
                        end
                        default: begin
                            state_nxt = IDLE;
                        end
                    endcase
                end
            end
            default: begin
                state_nxt = IDLE;
                div_nxt   = DIV_FULL;
                bit_nxt   = 3'd0;
            end
        endcase
    end

    // FSM state, datapath and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            div_cnt      <= DIV_FULL;
            bit_cnt      <= 3'd0;
            shift_reg    <= 8'h00;
            rx_data      <= 8'h00;
            rx_end       <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_busy      <= 1'b0;
        end else begin
            state        <= state_nxt;
            div_cnt      <= div_nxt;
            bit_cnt      <= bit_nxt;
            shift_reg    <= shift_nxt;
            rx_data      <= data_nxt;
            rx_end       <= end_nxt;
            rx_frame_err <= err_nxt;
            rx_busy      <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at DIV_RATE=15 (16-cycle bits).
// Frames are modelled in the bench; expected events are queued and matched on output pulses.
module tb_uart_rx;

    localparam int DIV_RATE = 15;
    localparam int BIT_CYC  = DIV_RATE + 1;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       rx_busy;
    logic       rx_end;
    logic       rx_frame_err;
    logic [7:0] rx_data;

    int total = 0;
    int bad   = 0;
    int end_cnt = 0;
    int err_cnt = 0;
    logic [8:0] exp_q[$];
    logic [7:0] last_good = 8'h00;
    logic prev_end = 1'b0;
    logic prev_err = 1'b0;

    uart_rx #(.DIV_RATE(DIV_RATE), .DIV_CNT_W(9)) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .rx_busy(rx_busy),
        .rx_end(rx_end),
        .rx_frame_err(rx_frame_err),
        .rx_data(rx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: match each output pulse against the oldest queued frame.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rx_end || rx_frame_err) begin
            if (rx_end) end_cnt++;
            if (rx_frame_err) err_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event end=%0b err=%0b data=%h", rx_end, rx_frame_err, rx_data);
            end else begin
                e = exp_q.pop_front();
                if (rx_end !== ~e[8] || rx_frame_err !== e[8] ||
                    rx_data !== (e[8] ? last_good : e[7:0])) begin
                    bad++;
                    $display("FAIL frame_result got end=%0b err=%0b data=%h want end=%0b err=%0b data=%h",
                             rx_end, rx_frame_err, rx_data, ~e[8], e[8], e[8] ? last_good : e[7:0]);
                end
                if (!e[8]) last_good = e[7:0];
            end
            total++;
            if (rx_busy !== 1'b0) begin
                bad++;
                $display("FAIL busy_at_pulse got %0b want 0", rx_busy);
            end
            total++;
            if ((rx_end && prev_end) || (rx_frame_err && prev_err)) begin
                bad++;
                $display("FAIL pulse_width got multi-cycle pulse want 1 cycle");
            end
        end
        prev_end = rx_end;
        prev_err = rx_frame_err;
    end

    task automatic send_frame(input logic [7:0] d, input logic stop);
        exp_q.push_back({~stop, d});
        rx = 1'b0;
        repeat (BIT_CYC) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT_CYC) @(posedge clk);
            #1;
        end
        rx = stop;
        repeat (BIT_CYC) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        rx    = 1'b1;
        idle(3);
        total++;
        if ({rx_busy, rx_end, rx_frame_err, rx_data} !== 11'h000) begin
            bad++;
            $display("FAIL reset_state got busy=%0b end=%0b err=%0b data=%h want all 0",
                     rx_busy, rx_end, rx_frame_err, rx_data);
        end
        reset = 1'b1;
        idle(5);
    endtask

    task automatic test_a5;
        int e0;
        e0 = end_cnt;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                idle(4 * BIT_CYC);
                total++;
                if (rx_busy !== 1'b1) begin
                    bad++;
                    $display("FAIL busy_mid_frame got %0b want 1", rx_busy);
                end
            end
        join
        idle(5);
        total++;
        if (end_cnt !== e0 + 1 || rx_data !== 8'hA5) begin
            bad++;
            $display("FAIL a5_frame got ends=%0d data=%h want ends=%0d data=a5", end_cnt - e0, rx_data, 1);
        end
    endtask

    task automatic test_false_start;
        int e0, r0;
        e0 = end_cnt;
        r0 = err_cnt;
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(3 * BIT_CYC);
        total++;
        if (end_cnt !== e0 || err_cnt !== r0 || rx_data !== 8'hA5 || rx_busy !== 1'b0) begin
            bad++;
            $display("FAIL false_start got ends=%0d errs=%0d data=%h busy=%0b want 0 0 a5 0",
                     end_cnt - e0, err_cnt - r0, rx_data, rx_busy);
        end
    endtask

    task automatic test_frame_err;
        int r0, e0;
        r0 = err_cnt;
        e0 = end_cnt;
        send_frame(8'h3C, 1'b0);
        idle(4 * BIT_CYC);
        total++;
        if (err_cnt !== r0 + 1 || end_cnt !== e0 || rx_data !== 8'hA5) begin
            bad++;
            $display("FAIL frame_err got errs=%0d ends=%0d data=%h want 1 0 a5",
                     err_cnt - r0, end_cnt - e0, rx_data);
        end
        total++;
        if (rx_busy !== 1'b0) begin
            bad++;
            $display("FAIL held_low_busy got %0b want 0", rx_busy);
        end
        rx = 1'b1;
        idle(2 * BIT_CYC);
        send_frame(8'h42, 1'b1);
        idle(5);
        total++;
        if (rx_data !== 8'h42) begin
            bad++;
            $display("FAIL recover_after_low got %h want 42", rx_data);
        end
    endtask

    task automatic test_back_to_back;
        int e0;
        logic [7:0] seen0;
        e0 = end_cnt;
        seen0 = 8'hxx;
        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
            end
            begin
                for (int i = 0; i < 12 * BIT_CYC && end_cnt == e0; i++) idle(1);
                seen0 = rx_data;
            end
        join
        idle(5);
        total++;
        if (end_cnt !== e0 + 2 || seen0 !== 8'h00 || rx_data !== 8'hFF) begin
            bad++;
            $display("FAIL back_to_back got ends=%0d first=%h last=%h want 2 00 ff",
                     end_cnt - e0, seen0, rx_data);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] d;
        int e0, r0;
        d  = 8'h5A;
        e0 = end_cnt;
        r0 = err_cnt;
        rx = 1'b0;
        idle(BIT_CYC);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            idle(BIT_CYC);
        end
        rx = d[4];
        idle(5);
        #3;
        reset = 1'b0;
        last_good = 8'h00;
        #1;
        total++;
        if ({rx_busy, rx_end, rx_frame_err, rx_data} !== 11'h000) begin
            bad++;
            $display("FAIL async_reset got busy=%0b end=%0b err=%0b data=%h want all 0",
                     rx_busy, rx_end, rx_frame_err, rx_data);
        end
        rx = 1'b1;
        idle(4);
        reset = 1'b1;
        idle(3 * BIT_CYC);
        total++;
        if (end_cnt !== e0 || err_cnt !== r0 || rx_data !== 8'h00) begin
            bad++;
            $display("FAIL abort_no_pulse got ends=%0d errs=%0d data=%h want 0 0 00",
                     end_cnt - e0, err_cnt - r0, rx_data);
        end
        send_frame(8'h81, 1'b1);
        idle(5);
        total++;
        if (rx_data !== 8'h81) begin
            bad++;
            $display("FAIL after_reset_frame got %h want 81", rx_data);
        end
    endtask

    task automatic test_stream;
        int e0, r0;
        e0 = end_cnt;
        r0 = err_cnt;
        for (int b = 0; b < 256; b++) send_frame(8'(b), 1'b1);
        idle(5);
        total++;
        if (end_cnt !== e0 + 256 || err_cnt !== r0 || rx_data !== 8'hFF) begin
            bad++;
            $display("FAIL stream_256 got ends=%0d errs=%0d last=%h want 256 0 ff",
                     end_cnt - e0, err_cnt - r0, rx_data);
        end
    endtask

    initial begin
        test_reset;
        test_a5;
        test_false_start;
        test_frame_err;
        test_back_to_back;
        test_reset_mid_frame;
        test_stream;
        idle(2 * BIT_CYC);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_events got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DIV_RATE, default 260, meaning bit period minus one, in clk cycles; one bit lasts DIV_RATE+1 cycles.
REQ-002 SHALL have parameter DIV_CNT_W, default 9, meaning divider counter width; DIV_RATE SHALL fit in DIV_CNT_W bits.
REQ-003 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, system reset.
REQ-005 Reset SHALL be asynchronous and active-low: assertion at any time forces reset state; release is sampled by clk.
REQ-006 SHALL have port rx, input, 1, UART RX pin, asynchronous to clk, idle high.
REQ-007 SHALL have port rx_busy, output, 1, high while a frame is being received.
REQ-008 SHALL have port rx_end, output, 1, one-cycle pulse when a valid frame completes.
REQ-009 SHALL have port rx_frame_err, output, 1, one-cycle pulse when the stop bit samples low.
REQ-010 SHALL have port rx_data, output, 8, last received byte, held until the next frame completes.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (rx_sync) before any use; both flops SHALL reset to 1.
REQ-012 SHALL implement states IDLE, START, DATA, STOP; rx_busy SHALL be high in START, DATA and STOP only.
REQ-013 IDLE -> START SHALL occur on a falling edge of rx_sync (previous 1, current 0), with div_cnt loaded to DIV_RATE/2 (integer division).
REQ-014 A low rx_sync without a preceding high (line held low) SHALL NOT start a frame.
REQ-015 In START, DATA and STOP, div_cnt SHALL decrement by 1 per cycle; at div_cnt==0 the bit is sampled and div_cnt reloads DIV_RATE.
REQ-016 START sample: rx_sync==0 SHALL go to DATA with bit_cnt=0; rx_sync==1 (false start) SHALL return to IDLE with no pulse and no rx_data change.
REQ-017 DATA samples SHALL be shifted LSB first into an 8-bit shift register; after the 8th sample (bit_cnt==7) the next state SHALL be STOP, otherwise bit_cnt increments.
REQ-018 STOP sample rx_sync==1: rx_data SHALL load the shift register, rx_end SHALL pulse for exactly one cycle, and the state SHALL return to IDLE.
REQ-019 STOP sample rx_sync==0: rx_frame_err SHALL pulse for exactly one cycle, rx_data SHALL NOT change, rx_end SHALL stay low, and the state SHALL return to IDLE.
REQ-020 rx_end/rx_frame_err SHALL be registered and assert on the cycle after the STOP sample edge; rx_busy SHALL be low on that same cycle.
REQ-021 Sampling point SHALL be DIV_RATE/2+1 cycles after the edge is seen on rx_sync for the start bit, then every DIV_RATE+1 cycles.
REQ-022 A new falling edge SHALL be accepted in the first IDLE cycle after the stop sample, so back-to-back frames from a transmitter with zero idle gap are received.
REQ-023 rx_sync edges during START/DATA/STOP other than at sample points SHALL be ignored.
REQ-024 div_cnt and bit_cnt SHALL never wrap: reload occurs only at 0, and bit_cnt is reset on IDLE->START.

Reset
REQ-025 On reset: state=IDLE, div_cnt=DIV_RATE, bit_cnt=0, shift register=0, rx_data=8'h00, rx_end=0, rx_frame_err=0, rx_busy=0, synchronizer flops=1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no rx_end or rx_frame_err pulse and rx_data=8'h00; after release, reception resumes at the next falling edge.

Verification (DIV_RATE=15, bit = 16 cycles)
REQ-027 Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> rx_busy high for the frame, rx_data=8'hA5, rx_end high exactly 1 cycle, rx_frame_err stays 0.
REQ-028 rx low for 4 cycles then high -> START sample reads 1, returns to IDLE, no pulses, rx_data unchanged.
REQ-029 Frame 0x3C with stop bit 0 -> rx_frame_err 1-cycle pulse, rx_end 0, rx_data keeps previous 8'hA5; line held low afterward -> no new frame until rx goes high then low.
REQ-030 Frames 0x00 then 0xFF with zero idle gap -> two rx_end pulses, rx_data 8'h00 then 8'hFF.
REQ-031 Reset asserted during bit 4 of frame 0x5A -> outputs at reset values immediately (asynchronously), no pulses; next frame 0x81 -> rx_data=8'h81.
REQ-032 Connected to the team's uart_tx at the same DIV_RATE, 256 bytes 0x00..0xFF -> every byte received in order with no frame errors.
